// File: rtl/rvseed_rd_arb.sv
// rvseed_rd_arb
// Shares one AXI read master port (AR + R) between two requesters:
// requester 0 is the instruction fetch unit and requester 1 is the load unit.
// Only one read transaction is in flight at a time. The AR and R paths are
// combinational pass-through muxes that steer by the latched grant.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   enable                gates new grants only; in-flight work completes
//   m0_* / m1_*           requester AR inputs, R outputs, arready/rready
//   s_*                   shared bus master port (AR outputs, R inputs)
//   gnt                   current or last granted requester (debug)
//   busy                  a transaction is in ADDR or DATA

`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif
`ifndef AXI_LOCK_WIDTH
`define AXI_LOCK_WIDTH 1
`endif
`ifndef AXI_CACHE_WIDTH
`define AXI_CACHE_WIDTH 4
`endif
`ifndef AXI_PROT_WIDTH
`define AXI_PROT_WIDTH 3
`endif
`ifndef AXI_QOS_WIDTH
`define AXI_QOS_WIDTH 4
`endif
`ifndef AXI_REGION_WIDTH
`define AXI_REGION_WIDTH 4
`endif

module rvseed_rd_arb #(
   parameter int FIXED_PRIO = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   // requester 0
   input  logic                          m0_arvalid,
   output logic                          m0_arready,
   input  logic [`AXI_ID_WIDTH-1:0]      m0_arid,
   input  logic [`AXI_ADDR_WIDTH-1:0]    m0_araddr,
   input  logic [`AXI_LEN_WIDTH-1:0]     m0_arlen,
   input  logic [`AXI_SIZE_WIDTH-1:0]    m0_arsize,
   input  logic [`AXI_BURST_WIDTH-1:0]   m0_arburst,
   output logic                          m0_rvalid,
   input  logic                          m0_rready,
   output logic [`AXI_ID_WIDTH-1:0]      m0_rid,
   output logic [`AXI_DATA_WIDTH-1:0]    m0_rdata,
   output logic [`AXI_RESP_WIDTH-1:0]    m0_rresp,
   output logic                          m0_rlast,
   // requester 1
   input  logic                          m1_arvalid,
   output logic                          m1_arready,
   input  logic [`AXI_ID_WIDTH-1:0]      m1_arid,
   input  logic [`AXI_ADDR_WIDTH-1:0]    m1_araddr,
   input  logic [`AXI_LEN_WIDTH-1:0]     m1_arlen,
   input  logic [`AXI_SIZE_WIDTH-1:0]    m1_arsize,
   input  logic [`AXI_BURST_WIDTH-1:0]   m1_arburst,
   output logic                          m1_rvalid,
   input  logic                          m1_rready,
   output logic [`AXI_ID_WIDTH-1:0]      m1_rid,
   output logic [`AXI_DATA_WIDTH-1:0]    m1_rdata,
   output logic [`AXI_RESP_WIDTH-1:0]    m1_rresp,
   output logic                          m1_rlast,
   // shared bus port
   output logic                          s_arvalid,
   input  logic                          s_arready,
   output logic [`AXI_ID_WIDTH-1:0]      s_arid,
   output logic [`AXI_ADDR_WIDTH-1:0]    s_araddr,
   output logic [`AXI_LEN_WIDTH-1:0]     s_arlen,
   output logic [`AXI_SIZE_WIDTH-1:0]    s_arsize,
   output logic [`AXI_BURST_WIDTH-1:0]   s_arburst,
   output logic [`AXI_LOCK_WIDTH-1:0]    s_arlock,
   output logic [`AXI_CACHE_WIDTH-1:0]   s_arcache,
   output logic [`AXI_PROT_WIDTH-1:0]    s_arprot,
   output logic [`AXI_QOS_WIDTH-1:0]     s_arqos,
   output logic [`AXI_REGION_WIDTH-1:0]  s_arregion,
   input  logic                          s_rvalid,
   output logic                          s_rready,
   input  logic [`AXI_ID_WIDTH-1:0]      s_rid,
   input  logic [`AXI_DATA_WIDTH-1:0]    s_rdata,
   input  logic [`AXI_RESP_WIDTH-1:0]    s_rresp,
   input  logic                          s_rlast,
   // status
   output logic                          gnt,
   output logic                          busy
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t state, state_nxt;
   logic   prio;
   logic   grant_go, grant_pick, ar_fire, r_done;

   // A tie goes to prio in round-robin mode, to requester 0 in fixed mode.
   // With a single requester, m1_arvalid alone identifies it.
   assign grant_go   = enable && (m0_arvalid || m1_arvalid);
   assign grant_pick = (m0_arvalid && m1_arvalid)
                       ? ((FIXED_PRIO != 0) ? 1'b0 : prio)
                       : m1_arvalid;

   assign ar_fire = s_arvalid && s_arready;
   // s_rready is already zero outside DATA, so this only fires in DATA
   assign r_done  = s_rvalid && s_rready && s_rlast;

   // state register, grant and tie-break registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 1'b0;
         prio  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant_go)
            gnt <= grant_pick;
         if (r_done)
            prio <= ~gnt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_go) state_nxt = ADDR;
         ADDR:    if (ar_fire)  state_nxt = DATA;
         DATA:    if (r_done)   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // handshake steering; the non-granted side always sees zeros
   always_comb begin
      s_arvalid  = 1'b0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      case (state)
         ADDR: begin
            s_arvalid  = gnt ? m1_arvalid : m0_arvalid;
            m0_arready = !gnt && s_arready;
            m1_arready =  gnt && s_arready;
         end
         DATA: begin
            s_rready  = gnt ? m1_rready : m0_rready;
            m0_rvalid = !gnt && s_rvalid;
            m1_rvalid =  gnt && s_rvalid;
         end
         default: ;
      endcase
   end

   // AR payload follows the grant; it only matters while s_arvalid is high
   assign s_arid    = gnt ? m1_arid    : m0_arid;
   assign s_araddr  = gnt ? m1_araddr  : m0_araddr;
   assign s_arlen   = gnt ? m1_arlen   : m0_arlen;
   assign s_arsize  = gnt ? m1_arsize  : m0_arsize;
   assign s_arburst = gnt ? m1_arburst : m0_arburst;

   assign s_arlock   = '0;
   assign s_arcache  = '0;
   assign s_arprot   = '0;
   assign s_arqos    = '0;
   assign s_arregion = '0;

   // R payload is broadcast; rvalid alone says who owns the beat
   assign m0_rid   = s_rid;
   assign m0_rdata = s_rdata;
   assign m0_rresp = s_rresp;
   assign m0_rlast = s_rlast;
   assign m1_rid   = s_rid;
   assign m1_rdata = s_rdata;
   assign m1_rresp = s_rresp;
   assign m1_rlast = s_rlast;

   assign busy = (state != IDLE);

endmodule
